// File: rtl/ipbase_axi_wr_pkg.sv
// Shared types and debug-status bit positions for the AXI write arbiter.
package ipbase_axi_wr_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int DFX_CNT_LSB = 0;
  localparam int DFX_IDX_LSB = 16;
  localparam int DFX_BUSY    = 24;
  localparam int DFX_TMO     = 31;

endpackage

// File: rtl/ipbase_rr_pick.sv
// Rotating priority encoder: first set request searching upward from ptr, wrapping.
module ipbase_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0] sum;

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      if (req[sum[IDX_W-1:0]]) begin
        idx = sum[IDX_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipbase_intf_axi_wr_arbiter.sv
// Round-robin arbiter sharing one AW/W command port among NUM_REQ write requesters.
//   state    | meaning
//   ARB_IDLE | no grant; pick next requester with awvalid set
//   ARB_BUSY | grant held until AW handshake and W last handshake both done
module ipbase_intf_axi_wr_arbiter
  import ipbase_axi_wr_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int TLEN_WIDTH = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_awaddr,
  input  logic [NUM_REQ*TLEN_WIDTH-1:0] req_awlen,
  input  logic [NUM_REQ-1:0]            req_awvalid,
  output logic [NUM_REQ-1:0]            req_awready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_wlast,
  input  logic [NUM_REQ-1:0]            req_wvalid,
  output logic [NUM_REQ-1:0]            req_wready,
  output logic [ADDR_WIDTH-1:0]         m_awaddr,
  output logic [TLEN_WIDTH-1:0]         m_awlen,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic                          m_wlast,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic                          err_trig,
  output logic [31:0]                   dfx_sta
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 tmo_q, tmo_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             busy;
  logic             aw_fire;
  logic             w_fire;

  ipbase_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req_awvalid),
    .ptr (rr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign busy = (state_q == ARB_BUSY);

  always_comb begin
    m_awaddr    = '0;
    m_awlen     = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wlast     = 1'b0;
    m_wvalid    = 1'b0;
    req_awready = '0;
    req_wready  = '0;
    if (busy) begin
      m_awaddr             = req_awaddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
      m_awlen              = req_awlen[int'(grant_q)*TLEN_WIDTH +: TLEN_WIDTH];
      m_awvalid            = req_awvalid[grant_q] & ~aw_done_q;
      m_wdata              = req_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_wlast              = req_wlast[grant_q];
      m_wvalid             = req_wvalid[grant_q] & ~w_done_q;
      req_awready[grant_q] = m_awready & ~aw_done_q;
      req_wready[grant_q]  = m_wready & ~w_done_q;
    end
  end

  assign aw_fire  = m_awvalid & m_awready;
  assign w_fire   = m_wvalid & m_wready & m_wlast;
  // Fires on the increment that takes the watchdog to all-ones; saturation keeps it single.
  assign err_trig = busy & (wd_q == WD_MAX - 1'b1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    wd_d      = '0;
    tmo_d     = tmo_q | err_trig;
    if (state_q == ARB_IDLE) begin
      if (pick_any) begin
        state_d = ARB_BUSY;
        grant_d = pick_idx;
      end
    end else begin
      wd_d      = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
      aw_done_d = aw_done_q | aw_fire;
      w_done_d  = w_done_q | w_fire;
      if (aw_done_d && w_done_d) begin
        state_d   = ARB_IDLE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        rr_d      = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        cnt_d     = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      wd_q      <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    dfx_sta                        = '0;
    dfx_sta[DFX_CNT_LSB +: 16]     = cnt_q;
    dfx_sta[DFX_IDX_LSB +: 8]      = 8'(grant_q);
    dfx_sta[DFX_BUSY]              = busy;
    dfx_sta[DFX_TMO]               = tmo_q;
  end

endmodule

// File: tb/tb_ipbase_intf_axi_wr_arbiter.sv
// Bench for the round-robin AXI write arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_ipbase_intf_axi_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int TW = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [N*AW-1:0] req_awaddr = '0;
  logic [N*LW-1:0] req_awlen = '0;
  logic [N-1:0]    req_awvalid = '0;
  logic [N-1:0]    req_awready;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_wlast = '0;
  logic [N-1:0]    req_wvalid = '0;
  logic [N-1:0]    req_wready;
  logic [AW-1:0]   m_awaddr;
  logic [LW-1:0]   m_awlen;
  logic            m_awvalid;
  logic            m_awready = 1'b1;
  logic [DW-1:0]   m_wdata;
  logic            m_wlast;
  logic            m_wvalid;
  logic            m_wready = 1'b1;
  logic            err_trig;
  logic [31:0]     dfx_sta;

  ipbase_intf_axi_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TLEN_WIDTH(LW), .TIMEOUT_W(TW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_awaddr(req_awaddr), .req_awlen(req_awlen), .req_awvalid(req_awvalid),
    .req_awready(req_awready), .req_wdata(req_wdata), .req_wlast(req_wlast),
    .req_wvalid(req_wvalid), .req_wready(req_wready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .err_trig(err_trig), .dfx_sta(dfx_sta)
  );

  int checks = 0;
  int failures = 0;

  // requester behaviour
  logic [AW-1:0] r_addr [N];
  logic [LW-1:0] r_len  [N];
  logic [DW-1:0] r_data [N];
  logic          aw_pend[N];
  logic          w_pend [N];
  logic          wgap   [N];
  int            beat   [N];

  // reference model: one burst at a time, strict round robin from rr
  bit   mb, mawd, mwd, mtmo;
  int   mg, mrr, mcnt, mbc;
  logic [N-1:0] e_awr, e_wr;
  int   glog[$];
  bit   prev_busy;
  int   dut_err;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_pend();
    bit p = 0;
    for (int i = 0; i < N; i++) p |= aw_pend[i] | w_pend[i];
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_awaddr[i*AW +: AW] = r_addr[i];
      req_awlen[i*LW +: LW]  = r_len[i];
      req_awvalid[i]         = aw_pend[i];
      req_wvalid[i]          = w_pend[i] & ~wgap[i];
      req_wlast[i]           = w_pend[i] && (beat[i] == int'(r_len[i]));
      req_wdata[i*DW +: DW]  = r_data[i] + DW'(beat[i]);
    end
  endtask

  task automatic spawn(int i, logic [AW-1:0] addr, int len);
    r_addr[i]  = addr;
    r_len[i]   = LW'(len);
    r_data[i]  = {$urandom, $urandom};
    aw_pend[i] = 1'b1;
    w_pend[i]  = 1'b1;
    beat[i]    = 0;
  endtask

  task automatic rst_checks();
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_awaddr", m_awaddr, 0);
    chk("rst_m_awlen", m_awlen, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wlast", m_wlast, 0);
    chk("rst_req_awready", req_awready, 0);
    chk("rst_req_wready", req_wready, 0);
    chk("rst_err_trig", err_trig, 0);
    chk("rst_dfx_sta", dfx_sta, 0);
  endtask

  // Asserts reset off the clock edge, checks outputs before any edge, then releases.
  task automatic do_reset();
    sys_rst = 1'b1;
    #1;
    rst_checks();
    for (int i = 0; i < N; i++) begin
      aw_pend[i] = 0; w_pend[i] = 0; wgap[i] = 0; beat[i] = 0;
      r_addr[i] = '0; r_len[i] = '0; r_data[i] = '0;
    end
    drive();
    mb = 0; mawd = 0; mwd = 0; mtmo = 0; mg = 0; mrr = 0; mcnt = 0; mbc = 0;
    prev_busy = 0;
    glog.delete();
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic step();
    int g;
    logic e_awv, e_wv, e_wl, e_err, awf, wf;
    logic [31:0] e_dfx;
    drive();
    #1;
    g     = mg;
    e_awv = mb && req_awvalid[g] && !mawd;
    e_wv  = mb && req_wvalid[g] && !mwd;
    e_wl  = mb && req_wlast[g];
    e_awr = '0;
    e_wr  = '0;
    if (mb && m_awready && !mawd) e_awr[g] = 1'b1;
    if (mb && m_wready && !mwd) e_wr[g] = 1'b1;
    e_err = mb && (mbc + 1 == (1 << TW) - 1);
    e_dfx = {mtmo, 6'd0, mb, 8'(mg), 16'(mcnt)};
    chk("m_awvalid", m_awvalid, e_awv);
    chk("m_awaddr", m_awaddr, mb ? req_awaddr[g*AW +: AW] : '0);
    chk("m_awlen", m_awlen, mb ? req_awlen[g*LW +: LW] : '0);
    chk("m_wvalid", m_wvalid, e_wv);
    chk("m_wdata", m_wdata, mb ? req_wdata[g*DW +: DW] : '0);
    chk("m_wlast", m_wlast, e_wl);
    chk("req_awready", req_awready, e_awr);
    chk("req_wready", req_wready, e_wr);
    chk("err_trig", err_trig, e_err);
    chk("dfx_sta", dfx_sta, e_dfx);
    if (dfx_sta[24] && !prev_busy) glog.push_back(int'(dfx_sta[23:16]));
    prev_busy = dfx_sta[24];
    if (err_trig) dut_err++;
    @(posedge sys_clk);
    if (!mb) begin
      for (int k = 0; k < N; k++) begin
        if (req_awvalid[(mrr + k) % N]) begin
          mg = (mrr + k) % N;
          mb = 1;
          mbc = 0;
          break;
        end
      end
    end else begin
      mbc++;
      if (e_err) mtmo = 1;
      awf = e_awv && m_awready;
      wf  = e_wv && m_wready && req_wlast[g];
      mawd |= awf;
      mwd  |= wf;
      if (mawd && mwd) begin
        mb = 0; mawd = 0; mwd = 0;
        mrr  = (g + 1) % N;
        mcnt = (mcnt + 1) & 16'hFFFF;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (e_awr[i] && req_awvalid[i]) aw_pend[i] = 0;
      if (e_wr[i] && req_wvalid[i]) begin
        if (req_wlast[i]) w_pend[i] = 0;
        else beat[i]++;
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic drain(string tag);
    int n = 0;
    for (int i = 0; i < N; i++) wgap[i] = 0;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    while ((mb || any_pend()) && n < 200) begin
      step();
      n++;
    end
    chk(tag, {mb, any_pend()}, 0);
  endtask

  initial begin
    int c0, e0, n;
    dut_err = 0;
    @(negedge sys_clk);
    // reset state
    do_reset();

    // single requester 2, addr 0x1000, len 3
    spawn(2, 32'h0000_1000, 3);
    drain("single_drain");
    chk("single_cnt", dfx_sta[15:0], 1);
    chk("single_idle", dfx_sta[24], 0);

    // async reset mid-burst
    spawn(1, $urandom, 2);
    spawn(3, $urandom, 2);
    step(); step(); step();
    #2;
    do_reset();

    // all four continuously valid
    n = 0;
    while (glog.size() < 8 && n < 200) begin
      for (int i = 0; i < N; i++)
        if (!aw_pend[i] && !w_pend[i]) spawn(i, $urandom, $urandom_range(0, 2));
      step();
      n++;
    end
    drain("rr_drain");
    chk("rr_grant_count", glog.size() >= 8, 1);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("rr_order", glog[k], k % 4);

    // W before AW on requester 1
    c0 = mcnt;
    spawn(1, 32'h0000_2040, 2);
    m_awready = 1'b0;
    n = 0;
    while (w_pend[1] && n < 30) begin step(); n++; end
    chk("wfirst_w_done", w_pend[1], 0);
    step(); step();
    drain("wfirst_drain");
    chk("wfirst_cnt", dfx_sta[15:0], 16'(c0 + 1));
    spawn(0, $urandom, 0);
    spawn(2, $urandom, 0);
    n = glog.size();
    drain("rr_adv_drain");
    chk("rr_adv_next", (glog.size() > n) ? glog[n] : -1, 2);

    // AW and last W handshake in the same cycle
    c0 = mcnt;
    spawn(0, 32'h0000_3000, 0);
    step(); step(); step();
    chk("same_cycle_cnt", dfx_sta[15:0], 16'(c0 + 1));
    chk("same_cycle_idle", dfx_sta[24], 0);

    // wvalid without awvalid is never granted
    w_pend[0] = 1'b1;
    r_len[0]  = '0;
    beat[0]   = 0;
    for (int k = 0; k < 5; k++) step();
    chk("wonly_idle", dfx_sta[24], 0);
    w_pend[0] = 1'b0;

    // watchdog: m_awready stuck low
    e0 = dut_err;
    spawn(3, 32'h0000_4000, 1);
    m_awready = 1'b0;
    for (int k = 0; k < 22; k++) step();
    drain("tmo_drain");
    chk("tmo_err_pulses", dut_err - e0, 1);
    chk("tmo_sticky", dfx_sta[31], 1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      m_awready = 1'($urandom_range(0, 1));
      m_wready  = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (!aw_pend[i] && !w_pend[i] && $urandom_range(0, 3) == 0)
          spawn(i, $urandom, $urandom_range(0, 3));
        wgap[i] = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
